// File: rtl/fwft_fifo_serializer.sv
// rtl/fwft_fifo_serializer.sv - pops wide FWFT FIFO words and emits them as narrow valid/ready beats
// Optional build macro: FWFT_SER_MSB_FIRST_EN (emit most-significant slice of each word first)
module fwft_fifo_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int CWIDTH = $clog2(RATIO);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [CWIDTH-1:0] LAST_CNT = CWIDTH'(RATIO - 1);

  logic [0:0]          state_q, state_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] shreg_q, shreg_d;

  logic sending;
  logic handshake;
  logic last_beat;

  assign sending   = (state_q == SEND);
  assign handshake = sending && out_ready;
  assign last_beat = sending && (cnt_q == LAST_CNT);

  // A pop happens either to fill an idle engine or to chain the next word
  // onto the handshake of the final beat, so consecutive words have no gap.
  assign fifo_read = !rst && !fifo_empty &&
                     ((state_q == IDLE) || (handshake && last_beat));

  assign out_valid = sending;
  assign busy      = sending;
  assign out_last  = last_beat;

`ifdef FWFT_SER_MSB_FIRST_EN
  assign out_data = shreg_q[IN_WIDTH-1 -: OUT_WIDTH];
`else
  assign out_data = shreg_q[OUT_WIDTH-1:0];
`endif

  // Next-state: load on pop, otherwise advance one slice per accepted beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (fifo_read) begin
      shreg_d = fifo_dout;
      cnt_d   = '0;
      state_d = SEND;
    end else if (handshake) begin
`ifdef FWFT_SER_MSB_FIRST_EN
      shreg_d = shreg_q << OUT_WIDTH;
`else
      shreg_d = shreg_q >> OUT_WIDTH;
`endif
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset discards any partially sent word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_fwft_fifo_serializer.sv
// tb/tb_fwft_fifo_serializer.sv - directed and scoreboarded checks for fwft_fifo_serializer
module tb_fwft_fifo_serializer;

  logic        clk;
  logic        rst;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_read;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  logic [31:0] q[$];
  logic [31:0] exp_q[$];

  int n_checks;
  int n_err;

  fwft_fifo_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] beat_of(input logic [31:0] w, input int i);
`ifdef FWFT_SER_MSB_FIRST_EN
    return w[(3-i)*8 +: 8];
`else
    return w[i*8 +: 8];
`endif
  endfunction

  task automatic drive();
    fifo_empty = (q.size() == 0);
    if (!fifo_empty) fifo_dout = q[0];
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    drive();
  endtask

  // One clock: pop the FIFO model if a read was presented, then settle.
  task automatic tick();
    logic rd;
    #1;
    rd = fifo_read;
    @(posedge clk);
    #1;
    if (rd && q.size() != 0) void'(q.pop_front());
    drive();
    #1;
  endtask

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] acc;
    logic [31:0] expw;
    int rcv, pushed, reads, bad_rd, b, cyc;

    n_checks = 0;
    n_err = 0;
    rst = 1'b1;
    out_ready = 1'b1;
    fifo_dout = 32'h0;
    fifo_empty = 1'b1;

    // Reset state, with a word already waiting in the FIFO.
    push(32'hAABBCCDD);
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_read", fifo_read, 0);

    // Single word, sink always ready.
    rst = 1'b0;
    #1;
    check("t1_read", fifo_read, 1);
    check("t1_idle_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, beat_of(32'hAABBCCDD, i));
      check("t1_last", out_last, (i == 3));
      check("t1_noread", fifo_read, 0);
    end
    tick();
    check("t1_end_valid", out_valid, 0);
    check("t1_end_busy", busy, 0);

    // Back-to-back words, no gap.
    w0 = 32'h03020100;
    w1 = 32'h07060504;
    push(w0);
    push(w1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_valid", out_valid, 1);
      check("t2_data", out_data, beat_of((i < 4) ? w0 : w1, i % 4));
      check("t2_last", out_last, (i % 4 == 3));
      check("t2_read", fifo_read, (i == 3));
    end
    tick();
    check("t2_end_valid", out_valid, 0);

    // Backpressure during beat 1.
    push(32'h11223344);
    tick();
    check("t3_b0", out_data, beat_of(32'h11223344, 0));
    tick();
    check("t3_b1", out_data, beat_of(32'h11223344, 1));
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_data", out_data, beat_of(32'h11223344, 1));
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_last", out_last, 0);
      check("t3_hold_read", fifo_read, 0);
    end
    out_ready = 1'b1;
    tick();
    check("t3_b2", out_data, beat_of(32'h11223344, 2));
    tick();
    check("t3_b3", out_data, beat_of(32'h11223344, 3));
    check("t3_b3_last", out_last, 1);
    tick();
    check("t3_end_valid", out_valid, 0);

    // Empty FIFO with a toggling data bus.
    for (int i = 0; i < 20; i++) begin
      fifo_dout = $urandom;
      tick();
      check("t4_read", fifo_read, 0);
      check("t4_valid", out_valid, 0);
      check("t4_busy", busy, 0);
    end

    // Reset mid-word.
    push(32'hDEADBEEF);
    push(32'h12345678);
    tick();
    check("t5_b0", out_data, beat_of(32'hDEADBEEF, 0));
    tick();
    check("t5_b1", out_data, beat_of(32'hDEADBEEF, 1));
    rst = 1'b1;
    #1;
    check("t5_rst_read", fifo_read, 0);
    tick();
    check("t5_rst_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    check("t5_next_read", fifo_read, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_next_data", out_data, beat_of(32'h12345678, i));
      check("t5_next_last", out_last, (i == 3));
    end
    tick();
    check("t5_end_valid", out_valid, 0);

    // Random ready and FIFO occupancy against a scoreboard.
    rcv = 0; pushed = 0; reads = 0; bad_rd = 0; b = 0; cyc = 0; acc = 0;
    while (rcv < 1000 && cyc < 20000) begin
      out_ready = ($urandom % 4) != 0;
      if (pushed < 1000 && ($urandom % 3) == 0) begin
        w0 = $urandom;
        push(w0);
        exp_q.push_back(w0);
        pushed++;
      end
      #1;
      if (fifo_read) begin
        reads++;
        if (fifo_empty) bad_rd++;
      end
      if (out_valid && out_ready) begin
        check("rnd_last", out_last, (b == 3));
`ifdef FWFT_SER_MSB_FIRST_EN
        acc[(3-b)*8 +: 8] = out_data;
`else
        acc[b*8 +: 8] = out_data;
`endif
        if (b == 3) begin
          expw = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hX;
          check("rnd_word", acc, expw);
          rcv++;
          b = 0;
        end else begin
          b++;
        end
      end
      tick();
      cyc++;
    end
    check("rnd_done", rcv, 1000);
    check("rnd_reads", reads, 1000);
    check("rnd_read_empty", bad_rd, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
